eeprom_arbiter: RTL and testbench
=================================

# eeprom_arbiter

Shares one parallel EEPROM read port between two requesters, such as an instruction fetch path and a debug/loader path. It selects a requester and drives chip-enable and address for a fixed number of wait cycles. It then captures the read data and returns it with a one-cycle acknowledge. It sits between the requesters' control logic and the EEPROM model or device pins.

## Interface
Parameters:
- ADDR_W, 8, EEPROM address width
- DATA_W, 8, EEPROM data width
- WAIT_CYC, 3, access cycles with chip-enable asserted before data is captured; legal range 1..15

Ports:
- Clk  in  1  clock; all state changes on the rising edge
- Rst  in  1  reset; asynchronous, active-low
- req0  in  1  requester 0 read request; level, held until ack0
- addr0  in  ADDR_W  requester 0 address; stable while req0=1
- req1  in  1  requester 1 read request; level, held until ack1
- addr1  in  ADDR_W  requester 1 address; stable while req1=1
- ack0  out  1  one-cycle pulse: rdata valid for requester 0
- ack1  out  1  one-cycle pulse: rdata valid for requester 1
- rdata  out  DATA_W  captured read data; holds until the next capture
- ee_ce  out  1  EEPROM chip enable, active-high
- ee_addr  out  ADDR_W  EEPROM address
- ee_data  in  DATA_W  EEPROM read data
- busy  out  1  high in ACCESS and DONE
- grant_id  out  1  requester currently or most recently served

## Operation
- FSM states:
  - IDLE: ee_ce=0. If any req=1, choose a winner, latch its address into ee_addr, load the wait counter with WAIT_CYC-1, set grant_id, and go to ACCESS.
  - ACCESS: ee_ce=1 and ee_addr held. Decrement the counter each cycle. At count 0, capture ee_data into rdata, assert ack[grant_id], and go to DONE.
  - DONE: ee_ce=0, the ack is high for this single cycle, then go to IDLE unconditionally.
- Arbitration happens only in IDLE. A request that arrives during ACCESS or DONE waits.
- Round-robin, when enabled: a last-served pointer. On a tie, the requester not last served wins. The pointer updates at grant. Reset value is 1, so requester 0 wins the first tie.
- A single requester is granted regardless of the pointer.
- Dropping req mid-access is a protocol violation. The access still completes and the ack still pulses.
- The wait counter is 4 bits and never wraps: the count-0 decision precedes any decrement.
- All outputs are registered; there is no combinational path from input to output.

## Timing
- Reset values: ack0=0, ack1=0, rdata=0, ee_ce=0, ee_addr=0, busy=0, grant_id=0. The state is IDLE and the pointer is 1.
- Asserting Rst mid-operation forces all of the above immediately. An in-flight access is abandoned with no ack.
- Edge E0 samples req in IDLE. ee_ce and busy are high from E0 through E(WAIT_CYC).
- ack and the new rdata appear at edge E(WAIT_CYC) and last one cycle. ee_data is sampled at that edge.
- Each requester gets at most one ack per grant.
- The FSM returns to IDLE at E(WAIT_CYC+1), and new requests are sampled at E(WAIT_CYC+2). Sustained throughput is therefore one access per WAIT_CYC+2 cycles.
- A requester deasserts req on the edge after it sees ack. A req still high at the next IDLE sample is treated as a new request.

## Configuration
- Macro: EEPROM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin tie-break as described; the last-served pointer exists.
- Undefined: fixed priority, requester 0 always wins ties. The pointer is removed. Starvation of requester 1 is permitted.

## Test plan
All scenarios use WAIT_CYC=3 and an EEPROM model with ee_data = ee_addr ^ 8'hA5.
- Reset check: hold Rst=0, toggle all inputs -> every output stays at its reset value; release Rst -> FSM in IDLE, busy=0.
- Single read: req0=1, addr0=8'h05 sampled at E0 -> ee_ce high E0..E3, ee_addr=8'h05, ack0 high for E3..E4 only, rdata=8'hA0, ack1 never asserted.
- Tie, macro defined: req0 and req1 held, re-asserted after each ack, addresses 8'h10/8'h20 -> grant order 0,1,0,1, rdata alternates 8'hB5/8'h85.
- Tie, macro undefined: same stimulus -> four consecutive ack0, no ack1.
- Late arrival: req1 (addr 8'h33) raised during req0's ACCESS -> req1 is granted at E5 after ack0, and ack1 carries rdata=8'h96.
- Reset mid-access: Rst low one cycle after grant -> ee_ce and busy drop immediately with no ack pulse. After release with req0 still high, a fresh full access completes normally.

Source files
------------

// File: rtl/eeprom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : eeprom_arbiter
//  Description : Two-requester arbiter for one parallel EEPROM read port.
//                Grants one requester in IDLE, holds chip-enable and address
//                for WAIT_CYC cycles, captures the read data and returns it
//                with a one-cycle acknowledge to the granted requester.
//                Optional feature macro: EEPROM_ARB_ROUND_ROBIN_EN
//                  defined   -> round-robin tie-break (last-served pointer)
//                  undefined -> fixed priority, requester 0 wins ties
//  Revision    : 1.0 - initial release
// ============================================================================
module eeprom_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 3   // legal range 1..15
) (
  input  logic              Clk,
  input  logic              Rst,      // asynchronous, active-low
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              ee_ce,
  output logic [ADDR_W-1:0] ee_addr,
  input  logic [DATA_W-1:0] ee_data,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // The counter is loaded with WAIT_CYC-1 so that the capture happens on
  // the WAIT_CYC-th edge after the grant edge.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic       win;        // 1 when requester 1 wins the current arbitration
  logic       any_req;

  assign any_req = req0 | req1;

`ifdef EEPROM_ARB_ROUND_ROBIN_EN
  logic last_served;

  // Round-robin winner: a lone requester always wins, on a tie the one not
  // served last time wins.
  always_comb begin
    win = 1'b0;
    if (req1 && !req0)
      win = 1'b1;
    else if (req1 && req0)
      win = ~last_served;
  end

  // Last-served pointer moves only when a grant is issued.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      last_served <= 1'b1;
    else if (state == ST_IDLE && any_req)
      last_served <= win;
  end
`else
  // Fixed priority: requester 1 wins only when requester 0 is silent.
  always_comb begin
    win = req1 & ~req0;
  end
`endif

  // State sequencing: IDLE -> ACCESS (WAIT_CYC cycles) -> DONE -> IDLE.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (any_req) state <= ST_ACCESS;
        ST_ACCESS: if (wait_cnt == 4'd0) state <= ST_DONE;
        ST_DONE:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Wait counter: the zero test comes before any decrement, so it never wraps.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wait_cnt <= 4'd0;
    end else if (state == ST_IDLE && any_req) begin
      wait_cnt <= CNT_LOAD;
    end else if (state == ST_ACCESS && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Grant bookkeeping: winner id and its address are latched at the grant.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      grant_id <= 1'b0;
      ee_addr  <= '0;
    end else if (state == ST_IDLE && any_req) begin
      grant_id <= win;
      ee_addr  <= win ? addr1 : addr0;
    end
  end

  // Registered EEPROM strobe and busy flag.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ee_ce <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ee_ce <= any_req;
          busy  <= any_req;
        end
        ST_ACCESS: begin
          if (wait_cnt == 4'd0)
            ee_ce <= 1'b0;
        end
        ST_DONE: begin
          ee_ce <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          ee_ce <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Data capture and single-cycle acknowledge to the granted requester.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rdata <= '0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (state == ST_ACCESS && wait_cnt == 4'd0) begin
        rdata <= ee_data;
        ack0  <= ~grant_id;
        ack1  <= grant_id;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eeprom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eeprom_arbiter
//  Description : Self-checking bench for eeprom_arbiter (WAIT_CYC=3) with an
//                EEPROM model returning ee_addr ^ 8'hA5. Table vectors, hand
//                sequences for multi-cycle corners, then random traffic
//                checked against a transaction-schedule reference model.
//                Honours EEPROM_ARB_ROUND_ROBIN_EN for tie expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eeprom_arbiter;

  localparam int WAIT = 3;
`ifdef EEPROM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] addr0, addr1;
  logic       ack0, ack1;
  logic [7:0] rdata;
  logic       ee_ce;
  logic [7:0] ee_addr;
  logic [7:0] ee_data;
  logic       busy;
  logic       grant_id;
  logic [20:0] outs;

  assign ee_data = ee_addr ^ 8'hA5;
  assign outs    = {ack0, ack1, rdata, ee_ce, ee_addr, busy, grant_id};

  eeprom_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(WAIT)) dut (
    .Clk(clk), .Rst(rst_n),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .ee_ce(ee_ce), .ee_addr(ee_addr), .ee_data(ee_data),
    .busy(busy), .grant_id(grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no ack within cycle budget (t=%0t)", nm, $time);
  endtask

  typedef struct {
    logic       r0;
    logic [7:0] a0;
    logic       r1;
    logic [7:0] a1;
    logic       g;   // expected winner
    logic [7:0] d;   // expected rdata
  } vec_t;

  vec_t tbl[9];

  // One table access: present requests, expect exactly one ack WAIT+1
  // negedges later, then release and expect return to idle.
  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    bit  got;
    logic [7:0] ea;
    ea = v.g ? v.a1 : v.a0;
    @(negedge clk);
    req0 = v.r0; addr0 = v.a0; req1 = v.r1; addr1 = v.a1;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk($sformatf("vec%0d ee_ce", idx), 32'(ee_ce), 32'd1);
        chk($sformatf("vec%0d ee_addr", idx), 32'(ee_addr), 32'(ea));
      end
      if (ack0 || ack1) got = 1;
    end
    if (!got) begin
      timeout($sformatf("vec%0d ack", idx));
    end else begin
      chk($sformatf("vec%0d latency", idx), 32'(n), 32'(WAIT + 1));
      chk($sformatf("vec%0d ack0", idx), 32'(ack0), 32'(!v.g));
      chk($sformatf("vec%0d ack1", idx), 32'(ack1), 32'(v.g));
      chk($sformatf("vec%0d rdata", idx), 32'(rdata), 32'(v.d));
      chk($sformatf("vec%0d grant_id", idx), 32'(grant_id), 32'(v.g));
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d ack width", idx), 32'(ack0 | ack1), 32'd0);
    chk($sformatf("vec%0d idle busy", idx), 32'(busy), 32'd0);
  endtask

  // Random-phase reference model state (transaction schedule).
  int         e, nf, g_edge;
  bit         act, g_id, ptr, w;
  logic [7:0] g_addr;

  initial begin
    int n;
    bit got;
    rst_n = 1'b0; req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;

    // ---------------- reset: inputs toggle, outputs stay at reset ----------
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req0 = 1'($urandom); req1 = 1'($urandom);
      addr0 = 8'($urandom); addr1 = 8'($urandom);
      chk("reset outputs", 32'(outs), 32'd0);
    end
    @(negedge clk);
    req0 = 0; req1 = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset outputs", 32'(outs), 32'd0);

    // ---------------- table vectors ---------------------------------------
    tbl[0] = '{1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 8'hA0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 8'h96};
    tbl[2] = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b0, 8'hB5};
    tbl[3] = '{1'b1, 8'h10, 1'b1, 8'h20, RR, RR ? 8'h85 : 8'hB5};
    tbl[4] = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b0, 8'hB5};
    tbl[5] = '{1'b1, 8'h10, 1'b1, 8'h20, RR, RR ? 8'h85 : 8'hB5};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h5A};
    tbl[7] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5};
    tbl[8] = '{1'b1, 8'h10, 1'b1, 8'h20, RR, RR ? 8'h85 : 8'hB5};
    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // ---------------- late arrival during ACCESS --------------------------
    @(negedge clk); req0 = 1; addr0 = 8'h05;
    @(negedge clk);                          // after E0
    @(negedge clk); req1 = 1; addr1 = 8'h33; // after E1
    @(negedge clk);                          // after E2
    @(negedge clk);                          // after E3
    chk("late ack0", 32'(ack0), 32'd1);
    chk("late ack1 early", 32'(ack1), 32'd0);
    chk("late rdata0", 32'(rdata), 32'hA0);
    req0 = 0;
    @(negedge clk);                          // after E4
    chk("late idle busy", 32'(busy), 32'd0);
    chk("late ack0 width", 32'(ack0), 32'd0);
    @(negedge clk);                          // after E5
    chk("late grant_id", 32'(grant_id), 32'd1);
    chk("late ee_ce", 32'(ee_ce), 32'd1);
    chk("late ee_addr", 32'(ee_addr), 32'h33);
    repeat (3) @(negedge clk);               // after E8
    chk("late ack1", 32'(ack1), 32'd1);
    chk("late rdata1", 32'(rdata), 32'h96);
    req1 = 0;
    @(negedge clk);
    chk("late ack1 width", 32'(ack1), 32'd0);

    // ---------------- req dropped mid-access still completes --------------
    @(negedge clk); req0 = 1; addr0 = 8'h44;
    @(negedge clk); req0 = 0;                // after E0
    chk("drop ee_ce", 32'(ee_ce), 32'd1);
    repeat (3) @(negedge clk);               // after E3
    chk("drop ack0", 32'(ack0), 32'd1);
    chk("drop rdata", 32'(rdata), 32'hE1);
    @(negedge clk);
    chk("drop no second ack", 32'(ack0 | ack1), 32'd0);

    // ---------------- reset mid-access -------------------------------------
    @(negedge clk); req0 = 1; addr0 = 8'h05;
    @(negedge clk);                          // after E0
    @(negedge clk);                          // after E1
    rst_n = 1'b0;
    #1;
    chk("midrst ee_ce", 32'(ee_ce), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("midrst outputs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (ack0 || ack1) got = 1;
    end
    if (!got) timeout("midrst fresh access");
    else begin
      chk("midrst latency", 32'(n), 32'(WAIT + 1));
      chk("midrst ack0", 32'(ack0), 32'd1);
      chk("midrst rdata", 32'(rdata), 32'hA0);
    end
    req0 = 0;
    @(negedge clk);
    chk("midrst ack width", 32'(ack0 | ack1), 32'd0);

    // ---------------- random traffic vs schedule model --------------------
    // Model: an arbitration happens at an edge where any req is high and the
    // port is free; ack follows WAIT edges later; the port is free again
    // WAIT+2 edges after the grant. Last served so far is requester 0.
    nf = 0; act = 0; g_id = 0; ptr = 0; g_edge = 0; g_addr = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      e = edge_cnt;
      chk("rnd ee_ce", 32'(ee_ce), 32'(act && e >= g_edge && e < g_edge + WAIT));
      chk("rnd busy", 32'(busy), 32'(act && e >= g_edge && e <= g_edge + WAIT));
      chk("rnd ack0", 32'(ack0), 32'(act && e == g_edge + WAIT && !g_id));
      chk("rnd ack1", 32'(ack1), 32'(act && e == g_edge + WAIT && g_id));
      chk("rnd grant_id", 32'(grant_id), 32'(g_id));
      if (act) chk("rnd ee_addr", 32'(ee_addr), 32'(g_addr));
      if (act && e >= g_edge + WAIT) chk("rnd rdata", 32'(rdata), 32'(g_addr ^ 8'hA5));
      if (act && e == g_edge + WAIT) begin
        if (g_id) req1 = 0; else req0 = 0;
      end
      if (!req0 && $urandom_range(0, 3) == 0) begin req0 = 1; addr0 = 8'($urandom); end
      if (!req1 && $urandom_range(0, 3) == 0) begin req1 = 1; addr1 = 8'($urandom); end
      if (e + 1 >= nf && (req0 || req1)) begin
        if (req0 && req1) w = RR ? !ptr : 1'b0;
        else              w = req1;
        g_id   = w;
        g_addr = w ? addr1 : addr0;
        g_edge = e + 1;
        nf     = e + 1 + WAIT + 2;
        act    = 1;
        ptr    = w;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
